// File: rtl/cond_exec_pkg.sv
// Shared types for the execute-stage predication unit: condition codes,
// flag bit positions, IT-block FSM states and the condition inversion helper.
package cond_exec_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
    MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
    HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
    GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
  } cond_t;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_t;

  // Conditions come in complementary pairs that differ only in bit 0.
  function automatic cond_t cond_invert(input cond_t c);
    return cond_t'(c ^ 4'h1);
  endfunction

endpackage

// File: rtl/cond_exec_if.sv
// Execute-stage control bundle between the decoder/pipeline and the
// predication unit. slave = predication unit, master = pipeline side.
interface cond_exec_if #(
  parameter int IT_DEPTH = 4,
  parameter int STAT_W   = 16
);
  localparam int LEN_W = $clog2(IT_DEPTH) + 1;

  logic                valid_e;
  logic                stall_e;
  logic                flush_e;
  logic [3:0]          cond_e;
  logic [3:0]          flags_alu_e;
  logic [1:0]          flag_write_e;
  logic                pcsrc_e;
  logic                reg_write_e;
  logic                mem_write_e;
  logic                branch_e;
  logic                no_write_e;
  logic                it_start_e;
  logic [3:0]          it_cond_e;
  logic [IT_DEPTH-1:0] it_mask_e;
  logic [LEN_W-1:0]    it_len_e;

  logic                pcsrc_out;
  logic                reg_write_out;
  logic                mem_write_out;
  logic                branch_taken_e;
  logic                cond_ex_e;
  logic [3:0]          flags_q;
  logic                it_active;
  logic [STAT_W-1:0]   exec_cnt;
  logic [STAT_W-1:0]   squash_cnt;

  modport slave (
    input  valid_e, stall_e, flush_e, cond_e, flags_alu_e, flag_write_e,
           pcsrc_e, reg_write_e, mem_write_e, branch_e, no_write_e,
           it_start_e, it_cond_e, it_mask_e, it_len_e,
    output pcsrc_out, reg_write_out, mem_write_out, branch_taken_e,
           cond_ex_e, flags_q, it_active, exec_cnt, squash_cnt
  );

  modport master (
    output valid_e, stall_e, flush_e, cond_e, flags_alu_e, flag_write_e,
           pcsrc_e, reg_write_e, mem_write_e, branch_e, no_write_e,
           it_start_e, it_cond_e, it_mask_e, it_len_e,
    input  pcsrc_out, reg_write_out, mem_write_out, branch_taken_e,
           cond_ex_e, flags_q, it_active, exec_cnt, squash_cnt
  );

endinterface

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: cond + {N,Z,C,V} -> pass.
module cond_eval
  import cond_exec_pkg::*;
(
  input  cond_t      cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;
  assign n = flags_i[N_BIT];
  assign z = flags_i[Z_BIT];
  assign c = flags_i[C_BIT];
  assign v = flags_i[V_BIT];

  // Decode the 16 condition codes against the committed flags.
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      EQ: pass_o = z;
      NE: pass_o = ~z;
      CS: pass_o = c;
      CC: pass_o = ~c;
      MI: pass_o = n;
      PL: pass_o = ~n;
      VS: pass_o = v;
      VC: pass_o = ~v;
      HI: pass_o = c & ~z;
      LS: pass_o = ~c | z;
      GE: pass_o = (n == v);
      LT: pass_o = (n != v);
      GT: pass_o = ~z & (n == v);
      LE: pass_o = z | (n != v);
      AL: pass_o = 1'b1;
      NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage predication unit: NZCV flags register, condition gating of
// pipeline controls, saturating executed/squashed counters.
// Optional IT-block FSM enabled by defining COND_EXEC_ITBLOCK_EN.
module cond_exec_unit
  import cond_exec_pkg::*;
#(
  parameter int IT_DEPTH = 4,
  parameter int STAT_W   = 16
) (
  input  logic       clk,
  input  logic       reset,
  cond_exec_if.slave bus
);

  localparam int LEN_W = $clog2(IT_DEPTH) + 1;

  logic              accept;
  logic              cond_pass;
  cond_t             eff_cond;
  logic [3:0]        flags_q;
  logic [STAT_W-1:0] exec_q;
  logic [STAT_W-1:0] squash_q;

  // A stalled or flushed instruction must not commit anything.
  assign accept = bus.valid_e & ~bus.stall_e & ~bus.flush_e & ~reset;

`ifdef COND_EXEC_ITBLOCK_EN
  localparam int SLOT_W = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;

  it_state_t           it_state_q;
  logic                it_active_q;
  cond_t               base_cond_q;
  logic [IT_DEPTH-1:0] mask_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [LEN_W-1:0]    remaining_q;
  logic [LEN_W-1:0]    len_d;

  // Clamp the requested block length into 1..IT_DEPTH.
  always_comb begin
    len_d = bus.it_len_e;
    if (len_d == '0) begin
      len_d = LEN_W'(1);
    end else if (len_d > LEN_W'(IT_DEPTH)) begin
      len_d = LEN_W'(IT_DEPTH);
    end
  end

  // Inside an IT block the slot's mask bit picks base or inverted condition.
  always_comb begin
    eff_cond = cond_t'(bus.cond_e);
    if (it_state_q == IT_ACTIVE) begin
      eff_cond = mask_q[slot_q] ? base_cond_q : cond_invert(base_cond_q);
    end
  end

  // IT-block FSM: opener loads the block, each accepted slot consumes one entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      it_state_q  <= IT_IDLE;
      it_active_q <= 1'b0;
      base_cond_q <= EQ;
      mask_q      <= '0;
      slot_q      <= '0;
      remaining_q <= '0;
    end else if (bus.flush_e) begin
      it_state_q  <= IT_IDLE;
      it_active_q <= 1'b0;
    end else if (accept) begin
      case (it_state_q)
        IT_IDLE: begin
          if (cond_pass && bus.it_start_e) begin
            it_state_q  <= IT_ACTIVE;
            it_active_q <= 1'b1;
            base_cond_q <= cond_t'(bus.it_cond_e);
            mask_q      <= bus.it_mask_e;
            slot_q      <= '0;
            remaining_q <= len_d;
          end
        end
        IT_ACTIVE: begin
          slot_q      <= slot_q + SLOT_W'(1);
          remaining_q <= remaining_q - LEN_W'(1);
          if (remaining_q <= LEN_W'(1)) begin
            it_state_q  <= IT_IDLE;
            it_active_q <= 1'b0;
          end
        end
        default: begin
          it_state_q  <= IT_IDLE;
          it_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.it_active = it_active_q;
`else
  logic             unused_it;
  logic [LEN_W-1:0] unused_it_len;

  assign eff_cond      = cond_t'(bus.cond_e);
  assign bus.it_active = 1'b0;
  assign unused_it     = ^{bus.it_start_e, bus.it_cond_e, bus.it_mask_e};
  assign unused_it_len = bus.it_len_e;
`endif

  cond_eval u_cond_eval (
    .cond_i (eff_cond),
    .flags_i(flags_q),
    .pass_o (cond_pass)
  );

  // Flags update only for accepted, condition-passing instructions; NZ and CV independently.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (accept && cond_pass) begin
      if (bus.flag_write_e[1]) begin
        flags_q[N_BIT] <= bus.flags_alu_e[N_BIT];
        flags_q[Z_BIT] <= bus.flags_alu_e[Z_BIT];
      end
      if (bus.flag_write_e[0]) begin
        flags_q[C_BIT] <= bus.flags_alu_e[C_BIT];
        flags_q[V_BIT] <= bus.flags_alu_e[V_BIT];
      end
    end
  end

  // Saturating statistics: executed vs squashed-by-condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (accept) begin
      if (cond_pass) begin
        if (~&exec_q) exec_q <= exec_q + STAT_W'(1);
      end else begin
        if (~&squash_q) squash_q <= squash_q + STAT_W'(1);
      end
    end
  end

  assign bus.cond_ex_e      = cond_pass & bus.valid_e & ~reset;
  assign bus.pcsrc_out      = bus.pcsrc_e & cond_pass & accept;
  assign bus.mem_write_out  = bus.mem_write_e & cond_pass & accept;
  assign bus.branch_taken_e = bus.branch_e & cond_pass & accept;
  assign bus.reg_write_out  = bus.reg_write_e & cond_pass & accept & ~bus.no_write_e;
  assign bus.flags_q        = flags_q;
  assign bus.exec_cnt       = exec_q;
  assign bus.squash_cnt     = squash_q;

endmodule
